// File: rtl/wir_ctrl.sv
// wir_ctrl: IEEE 1500 wrapper instruction register with opcode decode, DR strobe gating and WSO mux.
// Define WIR_PARITY_EN to add an odd-parity bit above the opcode in the WIR shift path.
`timescale 1ns/1ps
module wir_ctrl #(
  parameter int WIR_WIDTH = 8,
  parameter int NUM_WDR   = 4
) (
  input  logic                 wrck,
  input  logic                 wrstn,
  input  logic                 wsi,
  input  logic                 selectwir,
  input  logic                 capturewr,
  input  logic                 shiftwr,
  input  logic                 updatewr,
  input  logic [WIR_WIDTH-3:0] status_in,
  input  logic                 wby_so,
  input  logic                 wbr_so,
  input  logic [NUM_WDR-1:0]   wdr_so,
  output logic                 wso,
  output logic                 sel_wby,
  output logic                 sel_wbr,
  output logic [NUM_WDR-1:0]   sel_wdr,
  output logic [1:0]           wbr_mode,
  output logic                 dr_shift,
  output logic                 dr_capture,
  output logic                 dr_update,
  output logic                 illegal_op,
  output logic [WIR_WIDTH-1:0] wir_active
);

`ifdef WIR_PARITY_EN
  localparam int SR_W = WIR_WIDTH + 1;
`else
  localparam int SR_W = WIR_WIDTH;
`endif
  // Opcode comparisons are done at 17 bits so NUM_WDR never truncates at small WIR_WIDTH.
  localparam logic [16:0] OP_LIMIT = 17'(4 + NUM_WDR);

  logic [SR_W-1:0]      shift_reg;
  logic [SR_W-1:0]      shift_next;
  logic [WIR_WIDTH-1:0] upd_reg;
  logic                 illegal_reg;
  logic                 wso_reg;
  logic                 wso_next;
  logic [WIR_WIDTH-1:0] shift_op;
  logic [WIR_WIDTH-1:0] capture_val;
  logic [16:0]          upd_ext;
  logic                 op_legal;
  logic                 reg_so;

  assign capture_val = {status_in, 2'b01};
  assign shift_op    = shift_reg[WIR_WIDTH-1:0];

  always_comb begin
    shift_next = shift_reg;
    if (selectwir && shiftwr) begin
      shift_next = {shift_reg[SR_W-2:0], wsi};
    end else if (selectwir && capturewr) begin
`ifdef WIR_PARITY_EN
      shift_next = {~^capture_val, capture_val};
`else
      shift_next = capture_val;
`endif
    end
  end

`ifdef WIR_PARITY_EN
  assign op_legal = (17'(shift_op) < OP_LIMIT) && (shift_reg[WIR_WIDTH] == ~^shift_op);
`else
  assign op_legal = (17'(shift_op) < OP_LIMIT);
`endif

  always_ff @(posedge wrck or negedge wrstn) begin
    if (!wrstn) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_next;
    end
  end

  // Update and WSO retiming both live on the falling edge, away from the shift edge.
  always_ff @(negedge wrck or negedge wrstn) begin
    if (!wrstn) begin
      upd_reg     <= '0;
      illegal_reg <= 1'b0;
      wso_reg     <= 1'b0;
    end else begin
      if (selectwir && updatewr) begin
        upd_reg     <= op_legal ? shift_op : '0;
        illegal_reg <= ~op_legal;
      end
      wso_reg <= wso_next;
    end
  end

  assign upd_ext  = 17'(upd_reg);
  assign sel_wby  = (upd_ext == 17'd0);
  assign sel_wbr  = (upd_ext >= 17'd1) && (upd_ext <= 17'd3);
  assign wbr_mode = sel_wbr ? upd_reg[1:0] : 2'b00;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WDR; gi++) begin : g_wdr_sel
      assign sel_wdr[gi] = (upd_ext == 17'(4 + gi));
    end
  endgenerate

  assign reg_so   = (sel_wby & wby_so) | (sel_wbr & wbr_so) | (|(sel_wdr & wdr_so));
  assign wso_next = selectwir ? shift_reg[SR_W-1] : reg_so;

  assign dr_shift   = shiftwr   & ~selectwir;
  assign dr_capture = capturewr & ~selectwir;
  assign dr_update  = updatewr  & ~selectwir;

  assign wso        = wso_reg;
  assign illegal_op = illegal_reg;
  assign wir_active = upd_reg;

endmodule

// File: tb/tb_wir_ctrl.sv
// Self-checking bench for wir_ctrl: opcode table, hand-written corner sequences and random
// stimulus compared against a behavioural model of the WIR.
`timescale 1ns/1ps
module tb_wir_ctrl;
  localparam int W = 8;
  localparam int N = 4;
`ifdef WIR_PARITY_EN
  localparam int SR_W = W + 1;
`else
  localparam int SR_W = W;
`endif

  logic         wrck = 1'b0;
  logic         wrstn = 1'b1;
  logic         wsi = 1'b0;
  logic         selectwir = 1'b0;
  logic         capturewr = 1'b0;
  logic         shiftwr = 1'b0;
  logic         updatewr = 1'b0;
  logic [W-3:0] status_in = '0;
  logic         wby_so = 1'b0;
  logic         wbr_so = 1'b0;
  logic [N-1:0] wdr_so = '0;
  logic         wso;
  logic         sel_wby;
  logic         sel_wbr;
  logic [N-1:0] sel_wdr;
  logic [1:0]   wbr_mode;
  logic         dr_shift;
  logic         dr_capture;
  logic         dr_update;
  logic         illegal_op;
  logic [W-1:0] wir_active;

  wir_ctrl #(.WIR_WIDTH(W), .NUM_WDR(N)) dut (
    .wrck(wrck), .wrstn(wrstn), .wsi(wsi), .selectwir(selectwir),
    .capturewr(capturewr), .shiftwr(shiftwr), .updatewr(updatewr),
    .status_in(status_in), .wby_so(wby_so), .wbr_so(wbr_so), .wdr_so(wdr_so),
    .wso(wso), .sel_wby(sel_wby), .sel_wbr(sel_wbr), .sel_wdr(sel_wdr),
    .wbr_mode(wbr_mode), .dr_shift(dr_shift), .dr_capture(dr_capture),
    .dr_update(dr_update), .illegal_op(illegal_op), .wir_active(wir_active)
  );

  always #5 wrck = ~wrck;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: WIR contents as an integer, active opcode, sticky flag, last WSO bit.
  int unsigned m_sr;
  int unsigned m_act;
  bit          m_ill;
  bit          m_wso;

  typedef struct {
    logic [W-1:0] op;
    logic         e_wby;
    logic         e_wbr;
    logic [N-1:0] e_wdr;
    logic [1:0]   e_mode;
    logic         e_ill;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SR_W-1:0] enc(input logic [W-1:0] op);
    logic [SR_W-1:0] v;
    v = SR_W'(op);
`ifdef WIR_PARITY_EN
    v[W] = (($countones(op) % 2) == 0);
`endif
    return v;
  endfunction

  function automatic bit src_bit(input int unsigned act);
    if (act == 0) return wby_so;
    if (act <= 3) return wbr_so;
    return wdr_so[act-4];
  endfunction

  task automatic m_reset();
    m_sr = 0; m_act = 0; m_ill = 0; m_wso = 0;
  endtask

  task automatic model_neg();
    int unsigned op;
    bit ok;
    if (selectwir) m_wso = (m_sr >> (SR_W - 1)) & 1;
    else           m_wso = src_bit(m_act);
    if (selectwir && updatewr) begin
      op = m_sr & ((1 << W) - 1);
      ok = (op < 4 + N);
`ifdef WIR_PARITY_EN
      if (((m_sr >> W) & 1) != (($countones(op) % 2) == 0 ? 1 : 0)) ok = 0;
`endif
      m_act = ok ? op : 0;
      m_ill = !ok;
    end
  endtask

  task automatic model_pos();
    if (selectwir && shiftwr) begin
      m_sr = ((m_sr << 1) | int'(wsi)) & ((1 << SR_W) - 1);
    end else if (selectwir && capturewr) begin
      m_sr = (int'(status_in) << 2) | 1;
`ifdef WIR_PARITY_EN
      if ((($countones(status_in) + 1) % 2) == 0) m_sr = m_sr | (1 << W);
`endif
    end
  endtask

  task automatic check_all();
    chk("wso", wso, m_wso);
    chk("sel_wby", sel_wby, m_act == 0);
    chk("sel_wbr", sel_wbr, m_act >= 1 && m_act <= 3);
    chk("sel_wdr", sel_wdr, (m_act >= 4) ? (1 << (m_act - 4)) : 0);
    chk("wbr_mode", wbr_mode, (m_act >= 1 && m_act <= 3) ? m_act : 0);
    chk("illegal_op", illegal_op, m_ill);
    chk("wir_active", wir_active, m_act);
    chk("dr_shift", dr_shift, shiftwr && !selectwir);
    chk("dr_capture", dr_capture, capturewr && !selectwir);
    chk("dr_update", dr_update, updatewr && !selectwir);
  endtask

  // Called at posedge+1: one full wrck period, checking after the falling edge.
  task automatic step();
    @(negedge wrck);
    model_neg();
    #1;
    check_all();
    @(posedge wrck);
    model_pos();
    #1;
  endtask

  task automatic load_wir(input logic [SR_W-1:0] v);
    selectwir = 1; capturewr = 0; updatewr = 0; shiftwr = 1;
    for (int i = SR_W - 1; i >= 0; i--) begin
      wsi = v[i];
      step();
    end
    shiftwr = 0; wsi = 0; updatewr = 1;
    step();
    updatewr = 0;
  endtask

  task automatic reset_mid(input logic upd);
    selectwir = 1; shiftwr = 1; wsi = 1;
    step();
    step();
    updatewr = upd;
    #2 wrstn = 0;
    m_reset();
    #1;
    check_all();
    chk("rst_sel_wby", sel_wby, 1);
    chk("rst_wso", wso, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_wir_active", wir_active, 0);
    @(posedge wrck);
    #1;
    updatewr = 0; shiftwr = 0; wsi = 0;
    wrstn = 1;
    $display("reset mid-%s: sel_wby=%0b wso=%0b ill=%0b", upd ? "update" : "shift", sel_wby, wso, illegal_op);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cap_seq;
    cap_seq = 8'b1010_1001;
    tbl[0]  = '{8'h01, 1'b0, 1'b1, 4'b0000, 2'b01, 1'b0};
    tbl[1]  = '{8'h05, 1'b0, 1'b0, 4'b0010, 2'b00, 1'b0};
    tbl[2]  = '{8'hFF, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b1};
    tbl[3]  = '{8'h02, 1'b0, 1'b1, 4'b0000, 2'b10, 1'b0};
    tbl[4]  = '{8'h03, 1'b0, 1'b1, 4'b0000, 2'b11, 1'b0};
    tbl[5]  = '{8'h00, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0};
    tbl[6]  = '{8'h04, 1'b0, 1'b0, 4'b0001, 2'b00, 1'b0};
    tbl[7]  = '{8'h07, 1'b0, 1'b0, 4'b1000, 2'b00, 1'b0};
    tbl[8]  = '{8'h08, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b1};
    tbl[9]  = '{8'h06, 1'b0, 1'b0, 4'b0100, 2'b00, 1'b0};
    tbl[10] = '{8'h09, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b1};
    tbl[11] = '{8'h80, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b1};

    m_reset();
    #1 wrstn = 0;
    #2;
    check_all();
    chk("init_sel_wby", sel_wby, 1);
    chk("init_wso", wso, 0);
    @(posedge wrck);
    #1 wrstn = 1;

    for (int i = 0; i < 12; i++) begin
      load_wir(enc(tbl[i].op));
      chk("tbl_sel_wby", sel_wby, tbl[i].e_wby);
      chk("tbl_sel_wbr", sel_wbr, tbl[i].e_wbr);
      chk("tbl_sel_wdr", sel_wdr, tbl[i].e_wdr);
      chk("tbl_wbr_mode", wbr_mode, tbl[i].e_mode);
      chk("tbl_illegal", illegal_op, tbl[i].e_ill);
      $display("vec %0d op=%02h sel_wby=%0b sel_wbr=%0b sel_wdr=%b mode=%b ill=%0b",
               i, tbl[i].op, sel_wby, sel_wbr, sel_wdr, wbr_mode, illegal_op);
    end

    load_wir(enc(8'h01));
    selectwir = 0; shiftwr = 1; wbr_so = 1;
    #1 chk("extest_dr_shift", dr_shift, 1);
    step();
    chk("extest_wso1", wso, 1);
    wbr_so = 0;
    step();
    chk("extest_wso0", wso, 0);
    selectwir = 1;
    #1 chk("dr_shift_gated", dr_shift, 0);
    shiftwr = 0;
    $display("extest dr path: sel_wbr=%0b mode=%b", sel_wbr, wbr_mode);

    status_in = 6'h2A; selectwir = 1; capturewr = 1; shiftwr = 0;
    step();
    capturewr = 0; shiftwr = 1;
    for (int i = 0; i < 8; i++) begin
      wsi = 1'($urandom_range(0, 1));
      step();
`ifndef WIR_PARITY_EN
      chk("capture_wso", wso, cap_seq[7-i]);
`endif
    end
    shiftwr = 0;
    $display("capture 6'h2A shifted out");

    load_wir(enc(8'h00));
    status_in = 6'h01; capturewr = 1; shiftwr = 1; wsi = 1;
    step();
    capturewr = 0; shiftwr = 0; wsi = 0; updatewr = 1;
    step();
    updatewr = 0;
    chk("cap_shift_wbr", sel_wbr, 1);
    chk("cap_shift_mode", wbr_mode, 2'b01);
    $display("capture+shift: wir_active=%0h", wir_active);

    load_wir(enc(8'h06));
    for (int i = 0; i < 24; i++) begin
      selectwir = 1'($urandom_range(0, 1));
      shiftwr   = 1'($urandom_range(0, 1));
      capturewr = 1'($urandom_range(0, 1));
      wsi       = 1'($urandom_range(0, 1));
      status_in = 6'($urandom);
      step();
      chk("stable_active", wir_active, 8'h06);
      chk("stable_wdr", sel_wdr, 4'b0100);
    end
    selectwir = 1; shiftwr = 0; capturewr = 0;
    $display("stability: wir_active=%0h", wir_active);

`ifdef WIR_PARITY_EN
    load_wir(enc(8'h01) ^ (SR_W'(1) << W));
    chk("par_bad_ill", illegal_op, 1);
    chk("par_bad_wby", sel_wby, 1);
    load_wir(enc(8'h01));
    chk("par_ok_wbr", sel_wbr, 1);
    chk("par_ok_mode", wbr_mode, 2'b01);
    $display("parity: ill=%0b mode=%b", illegal_op, wbr_mode);
`endif

    load_wir(enc(8'h01));
    reset_mid(1'b0);
    load_wir(enc(8'hFF));
    reset_mid(1'b1);

    for (int i = 0; i < 400; i++) begin
      selectwir = ($urandom_range(0, 3) != 0);
      shiftwr   = 1'($urandom_range(0, 1));
      capturewr = ($urandom_range(0, 3) == 0);
      updatewr  = ($urandom_range(0, 7) == 0);
      wsi       = 1'($urandom_range(0, 1));
      status_in = 6'($urandom);
      wby_so    = 1'($urandom_range(0, 1));
      wbr_so    = 1'($urandom_range(0, 1));
      wdr_so    = 4'($urandom);
      step();
      if (selectwir && updatewr)
        $display("rand update %0d: wir_active=%0h ill=%0b", i, wir_active, illegal_op);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
